// File: rtl/hpdcache_mem_write_arbiter.sv
// Shares one HPDcache memory write interface between the writeback (0) and uncached (1) requesters.
// Optional perf counters are built when HPDCACHE_MEM_WARB_PERF_EN is defined.

typedef struct packed {
  logic [63:0] mem_req_addr;
  logic [7:0]  mem_req_len;
  logic [3:0]  mem_req_id;
} hpdcache_mem_warb_req_t;

typedef struct packed {
  logic [63:0] mem_req_w_data;
  logic [7:0]  mem_req_w_be;
  logic        mem_req_w_last;
} hpdcache_mem_warb_req_w_t;

typedef struct packed {
  logic       mem_resp_w_is_atomic;
  logic [3:0] mem_resp_w_id;
} hpdcache_mem_warb_resp_w_t;

module hpdcache_mem_write_arbiter #(
  parameter type hpdcache_mem_req_t    = hpdcache_mem_warb_req_t,
  parameter type hpdcache_mem_req_w_t  = hpdcache_mem_warb_req_w_t,
  parameter type hpdcache_mem_resp_w_t = hpdcache_mem_warb_resp_w_t,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned ORDER_DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [1:0]                     req_valid_i,
  output logic [1:0]                     req_ready_o,
  input  hpdcache_mem_req_t [1:0]        req_i,
  input  logic [1:0]                     req_data_valid_i,
  output logic [1:0]                     req_data_ready_o,
  input  hpdcache_mem_req_w_t [1:0]      req_data_i,
  output logic [1:0]                     resp_valid_o,
  input  logic [1:0]                     resp_ready_i,
  output hpdcache_mem_resp_w_t [1:0]     resp_o,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output hpdcache_mem_req_t              mem_req_o,
  output logic                           mem_req_data_valid_o,
  input  logic                           mem_req_data_ready_i,
  output hpdcache_mem_req_w_t            mem_req_data_o,
  input  logic                           mem_resp_valid_i,
  output logic                           mem_resp_ready_o,
  input  hpdcache_mem_resp_w_t           mem_resp_i
`ifdef HPDCACHE_MEM_WARB_PERF_EN
  ,
  output logic [1:0][31:0]               perf_grant_o,
  output logic [31:0]                    perf_stall_o
`endif
);

  localparam int unsigned PTR_W = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ORDER_DEPTH);

  logic [ORDER_DEPTH-1:0] order_q;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   rr_q, lock_vld_q, lock_idx_q;
  logic                   fifo_full, fifo_empty, head;
  logic                   winner, req_hs, data_hs, pop, resp_owner;

  always_comb begin
    fifo_full  = (cnt_q == FULL_CNT);
    fifo_empty = (cnt_q == '0);
    head       = order_q[rd_ptr_q];

    // A stalled offer keeps its requester until accepted, whatever the RR pointer says.
    if (lock_vld_q)              winner = lock_idx_q;
    else if (req_valid_i[rr_q])  winner = rr_q;
    else                         winner = ~rr_q;

    mem_req_o       = req_i[winner];
    mem_req_valid_o = !rst_i && req_valid_i[winner] && !fifo_full;
    req_ready_o     = '0;
    if (!rst_i && !fifo_full) req_ready_o[winner] = mem_req_ready_i;
    req_hs = mem_req_valid_o && mem_req_ready_i;

    // Data always comes from the oldest granted request; no bypass around an empty FIFO.
    mem_req_data_o       = req_data_i[head];
    mem_req_data_valid_o = !rst_i && !fifo_empty && req_data_valid_i[head];
    req_data_ready_o     = '0;
    if (!rst_i && !fifo_empty) req_data_ready_o[head] = mem_req_data_ready_i;
    data_hs = mem_req_data_valid_o && mem_req_data_ready_i;
    pop     = data_hs && mem_req_data_o.mem_req_w_last;

    resp_owner   = mem_resp_i.mem_resp_w_id[ID_W-1];
    resp_o[0]    = mem_resp_i;
    resp_o[1]    = mem_resp_i;
    resp_valid_o = '0;
    if (!rst_i) resp_valid_o[resp_owner] = mem_resp_valid_i;
    mem_resp_ready_o = !rst_i && resp_ready_i[resp_owner];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      order_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      lock_vld_q <= 1'b0;
      lock_idx_q <= 1'b0;
    end else begin
      if (req_hs) begin
        order_q[wr_ptr_q] <= winner;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
        rr_q              <= ~winner;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q      <= cnt_q + CNT_W'(req_hs) - CNT_W'(pop);
      lock_vld_q <= mem_req_valid_o && !mem_req_ready_i;
      lock_idx_q <= winner;
    end
  end

`ifdef HPDCACHE_MEM_WARB_PERF_EN
  logic [1:0][31:0] perf_grant_q;
  logic [31:0]      perf_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_grant_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (req_hs && !winner && perf_grant_q[0] != '1) perf_grant_q[0] <= perf_grant_q[0] + 32'd1;
      if (req_hs &&  winner && perf_grant_q[1] != '1) perf_grant_q[1] <= perf_grant_q[1] + 32'd1;
      if (mem_req_valid_o && !mem_req_ready_i && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_grant_o = perf_grant_q;
  assign perf_stall_o = perf_stall_q;
`endif

`ifndef SYNTHESIS
  a_order_no_overflow:  assert property (@(posedge clk_i) disable iff (rst_i) !(req_hs && fifo_full));
  a_order_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(pop && fifo_empty));
  a_data_from_head:     assert property (@(posedge clk_i) disable iff (rst_i) data_hs |-> req_data_valid_i[head]);
`endif

endmodule

// File: tb/tb_hpdcache_mem_write_arbiter.sv
// Randomized scoreboard bench for hpdcache_mem_write_arbiter: RR grant, grant-ordered data, ID-routed responses.
module tb_hpdcache_mem_write_arbiter;

  localparam int DEPTH = 4;
  typedef hpdcache_mem_warb_req_t    req_t;
  typedef hpdcache_mem_warb_req_w_t  w_t;
  typedef hpdcache_mem_warb_resp_w_t rsp_t;
  typedef struct packed { logic owner; w_t beat; } dexp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [1:0]       req_valid_i = '0, req_ready_o;
  req_t [1:0]       req_i = '0;
  logic [1:0]       req_data_valid_i = '0, req_data_ready_o;
  w_t [1:0]         req_data_i = '0;
  logic [1:0]       resp_valid_o, resp_ready_i = '0;
  rsp_t [1:0]       resp_o;
  logic             mem_req_valid_o, mem_req_ready_i = 1'b0;
  req_t             mem_req_o;
  logic             mem_req_data_valid_o, mem_req_data_ready_i = 1'b0;
  w_t               mem_req_data_o;
  logic             mem_resp_valid_i = 1'b0, mem_resp_ready_o;
  rsp_t             mem_resp_i = '0;
`ifdef HPDCACHE_MEM_WARB_PERF_EN
  logic [1:0][31:0] perf_grant;
  logic [31:0]      perf_stall;
`endif

  hpdcache_mem_write_arbiter #(.ID_W(4), .ORDER_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_i(req_i),
    .req_data_valid_i(req_data_valid_i), .req_data_ready_o(req_data_ready_o), .req_data_i(req_data_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_o(resp_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_o(mem_req_o),
    .mem_req_data_valid_o(mem_req_data_valid_o), .mem_req_data_ready_i(mem_req_data_ready_i),
    .mem_req_data_o(mem_req_data_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o), .mem_resp_i(mem_resp_i)
`ifdef HPDCACHE_MEM_WARB_PERF_EN
    , .perf_grant_o(perf_grant), .perf_stall_o(perf_stall)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: requests per requester, beats waiting for their grant, beats in expected downstream order.
  req_t  exp_req [2][$];
  w_t    pend_beats [2][$];
  w_t    drv_beats [2][$];
  dexp_t exp_data [$];
  rsp_t  exp_resp [$];

  // Reference model state: who should win next, whether an offer is being held, granted-but-unfinished writes.
  bit   mon_en = 0;
  logic m_rr = 1'b0, m_stall = 1'b0, m_stall_w = 1'b0;
  req_t m_stall_req;
  int   m_out = 0;
  int   m_grants [2] = '{0, 0};
  int   m_stalls = 0;

  always @(negedge clk_i) begin
    int   out_dec, out_inc;
    logic ew, ro;
    dexp_t d;
    req_t  r;
    rsp_t  e;
    if (mon_en && !rst_i) begin
      out_dec = 0;
      out_inc = 0;
      if (m_out == 0) begin
        chk("data_idle_valid", mem_req_data_valid_o, 0);
        chk("data_idle_ready", req_data_ready_o, 0);
      end else if (exp_data.size() == 0) begin
        chk("data_model_empty", 1, 0);
      end else begin
        d = exp_data[0];
        chk("data_valid_route", mem_req_data_valid_o, req_data_valid_i[d.owner]);
        chk("data_ready_route", req_data_ready_o, mem_req_data_ready_i ? (2'b01 << d.owner) : 2'b00);
        if (mem_req_data_valid_o && mem_req_data_ready_i) begin
          void'(exp_data.pop_front());
          chk("data_beat", mem_req_data_o, d.beat);
          if (d.beat.mem_req_w_last) out_dec = 1;
        end
      end

      if (req_valid_i == 2'b00) begin
        chk("req_idle", mem_req_valid_o, 0);
      end else if (m_out >= DEPTH) begin
        chk("full_req_valid", mem_req_valid_o, 0);
        chk("full_req_ready", req_ready_o, 0);
      end else begin
        ew = m_stall ? m_stall_w : (req_valid_i[m_rr] ? m_rr : !m_rr);
        chk("req_valid", mem_req_valid_o, 1);
        chk("req_ready_route", req_ready_o, mem_req_ready_i ? (2'b01 << ew) : 2'b00);
        if (m_stall) chk("req_stable", mem_req_o, m_stall_req);
        else         chk("req_winner", mem_req_o, req_i[ew]);
        if (mem_req_ready_i) begin
          if (exp_req[ew].size() == 0) chk("req_unexpected", 1, 0);
          else begin
            r = exp_req[ew].pop_front();
            chk("req_order", mem_req_o, r);
            for (int b = 0; b <= int'(r.mem_req_len); b++)
              if (pend_beats[ew].size() > 0) begin
                d.owner = ew;
                d.beat  = pend_beats[ew].pop_front();
                exp_data.push_back(d);
              end
          end
          m_rr    = !ew;
          m_stall = 1'b0;
          m_grants[ew]++;
          out_inc = 1;
        end else begin
          m_stall     = 1'b1;
          m_stall_w   = ew;
          m_stall_req = req_i[ew];
          m_stalls++;
        end
      end
      m_out = m_out + out_inc - out_dec;

      if (mem_resp_valid_i) begin
        ro = mem_resp_i.mem_resp_w_id[3];
        chk("resp_valid_route", resp_valid_o, 2'b01 << ro);
        chk("resp_ready_route", mem_resp_ready_o, resp_ready_i[ro]);
        chk("resp_bcast", {resp_o[1], resp_o[0]}, {mem_resp_i, mem_resp_i});
        if (mem_resp_ready_o) begin
          if (exp_resp.size() == 0) chk("resp_unexpected", 1, 0);
          else begin
            e = exp_resp.pop_front();
            chk("resp_data", resp_o[ro], e);
          end
        end
      end else begin
        chk("resp_idle", resp_valid_o, 0);
      end
    end
  end

  function automatic bit busy();
    return exp_req[0].size() + exp_req[1].size() + drv_beats[0].size() + drv_beats[1].size()
           + exp_data.size() + exp_resp.size() != 0 || req_valid_i != 0 || req_data_valid_i != 0
           || mem_resp_valid_i;
  endfunction

  task automatic issue_req(input int k, input int max_len);
    req_t r;
    w_t   w;
    int   len;
    len = $urandom_range(1, max_len);
    r.mem_req_addr = {$urandom, $urandom};
    r.mem_req_len  = 8'(len - 1);
    r.mem_req_id   = {k[0], 3'($urandom)};
    exp_req[k].push_back(r);
    for (int b = 0; b < len; b++) begin
      w.mem_req_w_data = {$urandom, $urandom};
      w.mem_req_w_be   = 8'($urandom);
      w.mem_req_w_last = (b == len - 1);
      drv_beats[k].push_back(w);
      pend_beats[k].push_back(w);
    end
    req_i[k]       = r;
    req_valid_i[k] = 1'b1;
  endtask

  task automatic run_phase(input int ncyc, input int p_val, input int p_rdy, input int p_dry,
                           input int p_rsp, input int max_len, input bit drain);
    logic [1:0] hs_req, hs_dat;
    logic       hs_rsp, live;
    rsp_t       rs;
    for (int c = 0; c < ncyc || (drain && busy()); c++) begin
      if (c >= ncyc + 3000) begin
        chk("drain_timeout", 1, 0);
        break;
      end
      live = (c < ncyc);
      @(negedge clk_i);
      hs_req = req_valid_i & req_ready_o;
      hs_dat = req_data_valid_i & req_data_ready_o;
      hs_rsp = mem_resp_valid_i & mem_resp_ready_o;
      @(posedge clk_i);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (hs_req[k]) req_valid_i[k] = 1'b0;
        if (hs_dat[k]) begin
          void'(drv_beats[k].pop_front());
          req_data_valid_i[k] = 1'b0;
        end
        if (!req_valid_i[k] && live && int'($urandom_range(0, 99)) < p_val) issue_req(k, max_len);
        if (!req_data_valid_i[k] && drv_beats[k].size() > 0
            && (!live || int'($urandom_range(0, 99)) < p_val)) begin
          req_data_i[k]       = drv_beats[k][0];
          req_data_valid_i[k] = 1'b1;
        end
      end
      if (hs_rsp) mem_resp_valid_i = 1'b0;
      if (!mem_resp_valid_i && live && int'($urandom_range(0, 99)) < p_val) begin
        rs.mem_resp_w_is_atomic = 1'($urandom);
        rs.mem_resp_w_id        = 4'($urandom);
        exp_resp.push_back(rs);
        mem_resp_i       = rs;
        mem_resp_valid_i = 1'b1;
      end
      mem_req_ready_i      = !live || int'($urandom_range(0, 99)) < p_rdy;
      mem_req_data_ready_i = !live || int'($urandom_range(0, 99)) < p_dry;
      resp_ready_i         = live ? {int'($urandom_range(0, 99)) < p_rsp, int'($urandom_range(0, 99)) < p_rsp}
                                  : 2'b11;
    end
  endtask

  // Holds reset with every input active; outputs must stay quiet and all state must be flushed.
  task automatic reset_check(input string tag);
    @(posedge clk_i);
    #1;
    mon_en = 0;
    rst_i  = 1'b1;
    req_valid_i = 2'b11; req_data_valid_i = 2'b11; mem_resp_valid_i = 1'b1;
    mem_req_ready_i = 1'b1; mem_req_data_ready_i = 1'b1; resp_ready_i = 2'b11;
    mem_resp_i.mem_resp_w_id = 4'h8;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk({tag, "_req_ready"}, req_ready_o, 0);
      chk({tag, "_mem_req_valid"}, mem_req_valid_o, 0);
      chk({tag, "_data_ready"}, req_data_ready_o, 0);
      chk({tag, "_mem_data_valid"}, mem_req_data_valid_o, 0);
      chk({tag, "_resp_valid"}, resp_valid_o, 0);
      chk({tag, "_mem_resp_ready"}, mem_resp_ready_o, 0);
    end
`ifdef HPDCACHE_MEM_WARB_PERF_EN
    chk({tag, "_perf_grant"}, perf_grant, 0);
    chk({tag, "_perf_stall"}, perf_stall, 0);
`endif
    for (int k = 0; k < 2; k++) begin
      exp_req[k].delete(); pend_beats[k].delete(); drv_beats[k].delete();
      m_grants[k] = 0;
    end
    exp_data.delete(); exp_resp.delete();
    m_rr = 1'b0; m_stall = 1'b0; m_out = 0; m_stalls = 0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    req_valid_i = 2'b00; mem_resp_valid_i = 1'b0;
    // Beats offered with nothing granted must not leak through a flushed order FIFO.
    req_data_valid_i = 2'b11;
    mon_en = 1;
    @(negedge clk_i);
    chk({tag, "_post_data_valid"}, mem_req_data_valid_o, 0);
    chk({tag, "_post_data_ready"}, req_data_ready_o, 0);
    @(posedge clk_i);
    #1;
    req_data_valid_i = 2'b00;
  endtask

  task automatic perf_check(input string tag);
`ifdef HPDCACHE_MEM_WARB_PERF_EN
    @(negedge clk_i);
    chk({tag, "_perf_grant0"}, perf_grant[0], 32'(m_grants[0]));
    chk({tag, "_perf_grant1"}, perf_grant[1], 32'(m_grants[1]));
    chk({tag, "_perf_stall"}, perf_stall, 32'(m_stalls));
`else
    @(negedge clk_i);
    chk({tag, "_grant_total"}, 32'(m_grants[0] + m_grants[1]) != 0, 1);
`endif
  endtask

  initial begin
    reset_check("rst_init");
    run_phase(200, 100, 100, 100, 100, 1, 1);   // saturating single-beat traffic: strict alternation
    run_phase(600, 60, 50, 60, 70, 4, 1);       // mixed bursts with back-pressure on every channel
    run_phase(150, 100, 100, 0, 50, 4, 1);      // data withheld: order FIFO fills, then drains
    run_phase(400, 80, 30, 40, 50, 8, 1);       // long request stalls exercise grant locking
    perf_check("phases");
    run_phase(60, 100, 100, 50, 50, 6, 0);      // leave bursts in flight
    reset_check("rst_mid");
    run_phase(200, 70, 60, 60, 60, 4, 1);
    perf_check("after_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
